// File: rtl/receiver.sv
// UART 8N1 receiver: two-flop synchronizer, 16x oversampling divider and a
// frame FSM that samples every bit at its centre and reports framing errors.
`timescale 1ns/1ps

package definitions_pkg;
    parameter int CLOCK_RATE = 50_000_000;
    parameter int BAUD_RATE  = 115_200;
endpackage

module receiver #(
    parameter int CLOCK_RATE = definitions_pkg::CLOCK_RATE,
    parameter int BAUD_RATE  = definitions_pkg::BAUD_RATE,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enabled,
    input  logic       in,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       frame_error
);

    localparam int DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] TCNT_MAX = TW'(DIV - 1);
    localparam logic [SW-1:0] SCNT_MAX = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SCNT_MID = SW'(OVERSAMPLE / 2 - 1);

    if (DIV < 2) begin : g_bad_div
        $error("receiver: CLOCK_RATE / (BAUD_RATE * OVERSAMPLE) must be at least 2");
    end
    if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
        $error("receiver: OVERSAMPLE must be even and at least 4");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic [1:0]    sync_r;
    logic          rx_d_r;
    logic          rx_s;
    logic          fall_s;
    logic          tick_s;
    state_t        state_r;
    logic [TW-1:0] tcnt_r;
    logic [SW-1:0] scnt_r;
    logic [2:0]    bcnt_r;
    logic [7:0]    shreg_r;
    logic [7:0]    data_r;
    logic          valid_r;
    logic          busy_r;
    logic          frame_error_r;

    assign rx_s   = sync_r[1];
    assign fall_s = (rx_s == 1'b0) && (rx_d_r == 1'b1);
    assign tick_s = (tcnt_r == TCNT_MAX);

    assign data        = data_r;
    assign valid       = valid_r;
    assign busy        = busy_r;
    assign frame_error = frame_error_r;

    // Line synchronizer and edge history; keeps running while the receiver is disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= 2'b11;
            rx_d_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[0], in};
            rx_d_r <= sync_r[1];
        end
    end

    // Divider, bit counters and frame FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst || !enabled) begin
            state_r       <= S_IDLE;
            tcnt_r        <= {TW{1'b0}};
            scnt_r        <= {SW{1'b0}};
            bcnt_r        <= 3'd0;
            shreg_r       <= 8'h00;
            data_r        <= 8'h00;
            valid_r       <= 1'b0;
            busy_r        <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            valid_r       <= 1'b0;
            frame_error_r <= 1'b0;
            tcnt_r        <= tick_s ? {TW{1'b0}} : tcnt_r + TW'(1);

            case (state_r)
                S_IDLE: begin
                    busy_r <= 1'b0;
                    // Re-phase the divider so the first tick lands DIV clocks after the edge.
                    if (fall_s) begin
                        state_r <= S_START;
                        tcnt_r  <= {TW{1'b0}};
                        scnt_r  <= {SW{1'b0}};
                        bcnt_r  <= 3'd0;
                        busy_r  <= 1'b1;
                    end
                end
                S_START: begin
                    if (tick_s) begin
                        if (scnt_r == SCNT_MID) begin
                            if (rx_s) begin
                                state_r <= S_IDLE;
                                busy_r  <= 1'b0;
                            end else begin
                                scnt_r  <= {SW{1'b0}};
                                state_r <= S_DATA;
                            end
                        end else begin
                            scnt_r <= scnt_r + SW'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (tick_s) begin
                        if (scnt_r == SCNT_MAX) begin
                            shreg_r <= {rx_s, shreg_r[7:1]};
                            scnt_r  <= {SW{1'b0}};
                            bcnt_r  <= bcnt_r + 3'd1;
                            if (bcnt_r == 3'd7) begin
                                state_r <= S_STOP;
                            end
                        end else begin
                            scnt_r <= scnt_r + SW'(1);
                        end
                    end
                end
                S_STOP: begin
                    // Leave at mid stop bit so a start edge right after it is not missed.
                    if (tick_s) begin
                        if (scnt_r == SCNT_MAX) begin
                            if (rx_s) begin
                                data_r  <= shreg_r;
                                valid_r <= 1'b1;
                                busy_r  <= 1'b0;
                                state_r <= S_IDLE;
                            end else begin
                                frame_error_r <= 1'b1;
                                state_r       <= S_BREAK;
                            end
                        end else begin
                            scnt_r <= scnt_r + SW'(1);
                        end
                    end
                end
                S_BREAK: begin
                    busy_r <= 1'b1;
                    if (rx_s) begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for receiver: frames are queued as expected events when
// sent, and a negedge monitor pops and compares whenever an output strobe fires.
`timescale 1ns/1ps

module tb_receiver;

    localparam int CLOCK_RATE = 1_600_000;
    localparam int BAUD_RATE  = 10_000;
    localparam int OS         = 16;
    localparam int DIV        = CLOCK_RATE / (BAUD_RATE * OS);
    localparam int T          = DIV * OS;
    // Line change -> edge seen (3) -> start check (OS/2 ticks) -> stop sample (9 bits).
    localparam int LAT        = 3 + (OS / 2) * DIV + 9 * T;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        longint     cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enabled;
    logic       serial;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_error;

    longint     cyc = 0;
    int         checks = 0;
    int         passed = 0;
    exp_t       q[$];
    logic [7:0] last_good = 8'h00;

    receiver #(
        .CLOCK_RATE(CLOCK_RATE),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enabled    (enabled),
        .in         (serial),
        .data       (data),
        .valid      (valid),
        .busy       (busy),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (valid || frame_error) begin
            check("valid_and_frame_error_exclusive", longint'(valid && frame_error), 0);
            if (q.size() == 0) begin
                check("unexpected_output_strobe", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("event_kind_is_error", longint'(frame_error), longint'(e.is_err));
                check("event_data", longint'(data), longint'(e.data));
                check("event_latency_cycle", cyc, e.cyc);
            end
        end
    end

    // Drives the first n bits of a 10-bit frame vector, one bit time each.
    task automatic drive_bits(input logic [9:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            serial = bits[i];
            repeat (T) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        serial = 1'b1;
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap);
        exp_t e;
        if (stop_ok) last_good = b;
        e.is_err = !stop_ok;
        e.data   = last_good;
        e.cyc    = cyc + LAT;
        q.push_back(e);
        drive_bits({stop_ok, b, 1'b0}, 10);
        idle(gap);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, longint'(data), 0);
        check({tag, "_valid"}, longint'(valid), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_frame_error"}, longint'(frame_error), 0);
    endtask

    // Starts a frame, then aborts it mid data bit 4 with rst or enabled low.
    task automatic abort_frame(input logic [7:0] b, input bit use_enable);
        drive_bits({1'b1, b, 1'b0}, 5);
        serial = b[4];
        repeat (T / 2) @(posedge clk);
        #1;
        check("abort_busy_before", longint'(busy), 1);
        if (use_enable) enabled = 1'b0;
        else rst = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero(use_enable ? "disable_abort" : "reset_abort");
        rst       = 1'b0;
        enabled   = 1'b1;
        last_good = 8'h00;
        idle(T + 20);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        bit         ok;
        int         gap;

        rst     = 1'b1;
        enabled = 1'b1;
        serial  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        idle(20);

        // 1: simple good frame
        send_frame(8'hA5, 1'b1, 40);
        check("t1_busy_after", longint'(busy), 0);
        check("t1_data_held", longint'(data), 8'hA5);

        // 2: glitch shorter than half a bit
        serial = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("t2_busy_during_glitch", longint'(busy), 1);
        idle(60);
        check("t2_busy_after_glitch", longint'(busy), 0);
        idle(T);

        // 3: good frame then framing error; data must hold
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h3C, 1'b0, 40);
        check("t3_data_held", longint'(data), 8'h11);
        idle(T);

        // 4: long break, then a good frame
        begin
            exp_t e;
            e.is_err = 1'b1;
            e.data   = last_good;
            e.cyc    = cyc + LAT;
            q.push_back(e);
        end
        serial = 1'b0;
        repeat (3000) @(posedge clk);
        #1;
        check("t4_busy_in_break", longint'(busy), 1);
        idle(10);
        check("t4_busy_after_break", longint'(busy), 0);
        idle(T);
        send_frame(8'h01, 1'b1, T);

        // 5: back-to-back with no idle bit
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, T);

        // 6: abort mid-frame by reset, then by disable
        abort_frame(8'h96, 1'b0);
        send_frame(8'h5A, 1'b1, T);
        abort_frame(8'hC3, 1'b1);
        send_frame(8'h5A, 1'b1, T);

        // Randomized frames with occasional bad stop bits and random gaps
        for (int n = 0; n < 16; n++) begin
            b   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 7) != 0);
            gap = ok ? int'($urandom_range(0, 300)) : int'($urandom_range(20, 300));
            send_frame(b, ok, gap);
        end

        idle(2 * T);
        check("final_queue_empty", longint'(q.size()), 0);
        check("final_busy", longint'(busy), 0);
        check("final_data", longint'(data), longint'(last_good));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
